cached_memory: RTL and testbench
================================

# cached_memory

Read-only memory subsystem with a direct-mapped cache in front of a 32K-word main memory. It accepts a 15-bit word address and returns the 32-bit word, asserting `ready` when `mem_out` is valid. Hits complete combinationally in the same cycle; misses stall while a 4-word block is fetched from main memory. It is built from three sub-blocks: `cache_memory`, `main_memory` and `memory_controller`.

## Interface
- `WORD_LENGTH`, default 32: data word width (shared constant).
- `MEM_LATENCY`, default 4: main-memory access cycles per block fetch; must be ≥1.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `clear` input, 1 bit: reset, asynchronous, active-low.
- `address` input, 15 bits: word address; the requester holds it stable while `ready`=0.
- `ready` output, 1 bit: `mem_out` holds the word at `address` this cycle.
- `mem_out` output, `WORD_LENGTH` bits: read data; 0 when `ready`=0.
- `hit_count`, `access_count` outputs, 32 bits each: present only with `CACHE_STATS_EN`.

## Operation
- Address split: tag = `address[14:12]` (3 bits), index = `address[11:2]` (10 bits, 1024 lines), offset = `address[1:0]` (word in block).
- Cache storage: 1024 lines, each with a valid bit, a 3-bit tag and 4 words (4K words total).
- `hit` = valid[index] && tag[index]==tag. This is combinational.
- `mem_out` = hit ? line[index].word[offset] : 0.
- Main memory: 32768 words, read-only, combinational 4-word block output for `{address[14:2],2'b00}`..`+3`. It is initialised so that word[a] = a, zero-extended.
- Controller states:
  - COMPARE: `cache_read`=1 and `ready`=`hit`. On a miss, go to FETCH and load the counter with `MEM_LATENCY`-1.
  - FETCH: `ready`=0. The counter decrements each cycle. At 0, assert `cache_write` for one cycle. On that edge the line gets valid=1, the new tag and all 4 words, and the state returns to COMPARE.
- `cache_write` overwrites unconditionally. There is no dirty state and no write port.
- If `address` changes while `ready`=0, behaviour is undefined. The fetched block is whichever block `address` selects on the write edge.

## Timing
- Reset (clear=0), asynchronously: state→COMPARE, all valid bits→0, counter→0, stats→0. The 4 words and tags are not reset.
- Right after reset every access misses, so `ready`=0 and `mem_out`=0.
- Hit latency is 0: `ready` and `mem_out` respond combinationally in the same cycle `address` is applied in COMPARE.
- Miss latency: `ready` goes low in the cycle the address is applied. It stays low for `MEM_LATENCY` FETCH cycles and rises in the following COMPARE cycle (`MEM_LATENCY`+1 cycles after presentation, 5 by default).
- A new `address` may be applied in any cycle where `ready`=1. Back-to-back hits sustain one word per cycle.
- Reset mid-FETCH aborts the fill. The line is left invalid and the state returns to COMPARE.
- Index/tag conflicts evict silently. The old line is fully replaced.

## Configuration
- `CACHE_STATS_EN` defined:
  - `access_count` increments once per completed access (COMPARE cycle with `ready`=1 whose address differs from the previously completed one, or the first after reset).
  - `hit_count` increments for those completed without a FETCH.
  - Both are cleared by `clear` and saturate at all-ones.
- `CACHE_STATS_EN` undefined: the counters and their ports do not exist, and there is no other behavioural change.

## Structure
- The shared package holds `WORD_LENGTH`, the address field widths (TAG_W=3, INDEX_W=10, OFFSET_W=2), the line count, the block size and the controller state enum.
- Sub-modules:
  - `cache_memory` (tag/valid/data arrays, hit compare, word select).
  - `main_memory` (ROM array, block read).
  - `memory_controller` (FSM, latency counter, stats).
- The top level only wires these three together.

## Test plan
- Reset, then address 1024 → `ready`=0 for 5 cycles, then `ready`=1 and `mem_out`=1024.
- Then 1025, 1026, 1027 in consecutive cycles → each hits in the same cycle with `mem_out` equal to its address.
- 1024, then 5120 (same index, tag 1), then 1024 → all three miss with 5-cycle stalls, and `mem_out` is 1024, 5120, 1024.
- Sequential sweep 1024..9215 after reset → 2048 misses and 6144 hits. With `CACHE_STATS_EN`, `access_count`=8192 and `hit_count`=6144.
- Assert `clear` during FETCH of 2048, release, re-present 2048 → full 5-cycle miss again and correct data. A previously cached 1024 must also miss.
- `MEM_LATENCY`=1 build → miss stall is 2 cycles and data is correct.

Source files
------------

// File: rtl/cached_memory_pkg.sv
// Shared constants, address split and controller states for cached_memory.
// Optional statistics counters are enabled with `define CACHE_STATS_EN.
package cached_memory_pkg;

    parameter int WORD_LENGTH = 32;
    parameter int ADDR_W      = 15;
    parameter int TAG_W       = 3;
    parameter int INDEX_W     = 10;
    parameter int OFFSET_W    = 2;
    parameter int LINES       = 1 << INDEX_W;
    parameter int BLOCK_WORDS = 1 << OFFSET_W;
    parameter int STAT_W      = 32;

    typedef logic [WORD_LENGTH-1:0] word_t;
    typedef logic [BLOCK_WORDS-1:0][WORD_LENGTH-1:0] block_t;

    typedef enum logic {
        COMPARE,
        FETCH
    } ctrl_state_e;

    function automatic logic [TAG_W-1:0] addr_tag(
        input logic [ADDR_W-1:0] a
    );
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(
        input logic [ADDR_W-1:0] a
    );
        return a[OFFSET_W +: INDEX_W];
    endfunction

endpackage

// File: rtl/cached_memory_if.sv
// Requester-side bus of cached_memory.
// Stats ports exist only when CACHE_STATS_EN is defined.
interface cached_memory_if;
    import cached_memory_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              ready;
    word_t             mem_out;
`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] hit_count;
    logic [STAT_W-1:0] access_count;

    modport master (
        output address,
        input  ready,
        input  mem_out,
        input  hit_count,
        input  access_count
    );

    modport slave (
        input  address,
        output ready,
        output mem_out,
        output hit_count,
        output access_count
    );
`else
    modport master (
        output address,
        input  ready,
        input  mem_out
    );

    modport slave (
        input  address,
        output ready,
        output mem_out
    );
`endif

endinterface

// File: rtl/cache_memory.sv
// Direct-mapped cache storage: valid/tag/data arrays, hit compare, word select.
// Only the valid bits are reset; tags and data are qualified by them.
module cache_memory
    import cached_memory_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic [ADDR_W-1:0] address,
    input  logic              cache_read,
    input  logic              cache_write,
    input  block_t            fill,
    output logic              hit,
    output word_t             rd_data
);

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q [LINES];
    block_t           data_q [LINES];

    assign tag = addr_tag(address);
    assign idx = addr_index(address);
    assign off = address[OFFSET_W-1:0];

    always_comb begin
        valid_d = valid_q;
        if (cache_write) begin
            valid_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Fill replaces the whole line; conflicting lines are evicted silently.
    always_ff @(posedge clk) begin
        if (cache_write) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= fill;
        end
    end

    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign rd_data = (cache_read && hit) ? data_q[idx][off] : '0;

endmodule

// File: rtl/main_memory.sv
// Read-only 32K-word backing store; word[a] holds a, read a block at a time.
// The contents are a pure function of the address, so no array is stored.
module main_memory
    import cached_memory_pkg::*;
(
    input  logic [ADDR_W-OFFSET_W-1:0] blk_addr,
    output block_t                     block
);

    always_comb begin
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            block[w] = WORD_LENGTH'({blk_addr, OFFSET_W'(w)});
        end
    end

endmodule

// File: rtl/memory_controller.sv
// Miss handling FSM with block-fetch latency counter.
// Hit/access statistics are built only with CACHE_STATS_EN.
module memory_controller
    import cached_memory_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              clear,
`ifdef CACHE_STATS_EN
    input  logic [ADDR_W-1:0] address,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] access_count,
`endif
    input  logic              hit,
    output logic              ready,
    output logic              cache_read,
    output logic              cache_write
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    ctrl_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= COMPARE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                COMPARE: begin
                    if (!hit) begin
                        state_q <= FETCH;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                FETCH: begin
                    if (cnt_q == '0) begin
                        state_q <= COMPARE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= COMPARE;
            endcase
        end
    end

    assign cache_read  = (state_q == COMPARE);
    assign ready       = cache_read && hit;
    assign cache_write = (state_q == FETCH) && (cnt_q == '0);

`ifdef CACHE_STATS_EN
    logic [ADDR_W-1:0] last_q, last_d;
    logic              seen_q, seen_d;
    logic              fetched_q, fetched_d;
    logic [STAT_W-1:0] acc_q, acc_d;
    logic [STAT_W-1:0] hits_q, hits_d;
    logic              done;

    // An access completes once, even if its address is held for many cycles.
    assign done = ready && (!seen_q || (address != last_q));

    always_comb begin
        last_d    = last_q;
        seen_d    = seen_q;
        fetched_d = fetched_q;
        acc_d     = acc_q;
        hits_d    = hits_q;
        if (done) begin
            last_d = address;
            seen_d = 1'b1;
            if (acc_q != '1) begin
                acc_d = acc_q + 1'b1;
            end
            if (!fetched_q && (hits_q != '1)) begin
                hits_d = hits_q + 1'b1;
            end
        end
        if (ready) begin
            fetched_d = 1'b0;
        end else if (cache_read) begin
            fetched_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            last_q    <= '0;
            seen_q    <= 1'b0;
            fetched_q <= 1'b0;
            acc_q     <= '0;
            hits_q    <= '0;
        end else begin
            last_q    <= last_d;
            seen_q    <= seen_d;
            fetched_q <= fetched_d;
            acc_q     <= acc_d;
            hits_q    <= hits_d;
        end
    end

    assign hit_count    = hits_q;
    assign access_count = acc_q;
`endif

endmodule

// File: rtl/cached_memory.sv
// Read-only memory with a direct-mapped 4-word-block cache in front.
// Define CACHE_STATS_EN to expose hit_count/access_count on the bus.
module cached_memory
    import cached_memory_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input logic            clk,
    input logic            clear,
    cached_memory_if.slave bus
);

    block_t fill;
    logic   hit;
    logic   cache_read;
    logic   cache_write;

    main_memory u_main (
        .blk_addr (bus.address[ADDR_W-1:OFFSET_W]),
        .block    (fill)
    );

    cache_memory u_cache (
        .clk         (clk),
        .clear       (clear),
        .address     (bus.address),
        .cache_read  (cache_read),
        .cache_write (cache_write),
        .fill        (fill),
        .hit         (hit),
        .rd_data     (bus.mem_out)
    );

    memory_controller #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_ctrl (
        .clk          (clk),
        .clear        (clear),
`ifdef CACHE_STATS_EN
        .address      (bus.address),
        .hit_count    (bus.hit_count),
        .access_count (bus.access_count),
`endif
        .hit          (hit),
        .ready        (bus.ready),
        .cache_read   (cache_read),
        .cache_write  (cache_write)
    );

endmodule

// File: tb/tb_cached_memory.sv
// Scoreboard bench for cached_memory against a block-residency model.
module tb_cached_memory;
    import cached_memory_pkg::*;

    localparam int LAT = 4;

    typedef struct {
        logic [14:0] addr;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    cached_memory_if bus ();
    cached_memory_if bus1 ();

    cached_memory #(.MEM_LATENCY(LAT)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    cached_memory #(.MEM_LATENCY(1)) dut1 (
        .clk   (clk),
        .clear (clear),
        .bus   (bus1)
    );

    int passed = 0;
    int total = 0;

    exp_t sbq[$];
    exp_t m_e;
    int   cyc = 0;
    bit   done_flag = 0;
    int   obs_miss = 0;
    int   obs_hit = 0;

    // model: which block each line holds, plus completed-access counters
    int          line_blk[int];
    bit          m_first = 1;
    logic [14:0] m_last = '0;
    int          exp_acc = 0;
    int          exp_hits = 0;

    function automatic void check(input string name,
                                  input longint unsigned act,
                                  input longint unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic void model_reset();
        line_blk.delete();
        m_first  = 1;
        exp_acc  = 0;
        exp_hits = 0;
    endfunction

    function automatic int model_access(input logic [14:0] a);
        int blk = int'(a) / 4;
        int idx = blk % 1024;
        bit h   = line_blk.exists(idx) && (line_blk[idx] == blk);
        if (!h) line_blk[idx] = blk;
        if (m_first || a != m_last) begin
            exp_acc++;
            if (h) exp_hits++;
        end
        m_first = 0;
        m_last  = a;
        return h ? 0 : LAT + 1;
    endfunction

    always @(negedge clk) begin
        if (!clear) begin
            cyc = 0;
        end else begin
            if (!bus.ready) check("zero_when_stalled", bus.mem_out, 0);
            if (sbq.size() > 0) begin
                if (bus.ready) begin
                    m_e = sbq.pop_front();
                    check("data", bus.mem_out, 64'(m_e.addr));
                    check("latency", cyc, m_e.lat);
                    if (cyc == 0) obs_hit++;
                    else obs_miss++;
                    cyc = 0;
                    done_flag = 1;
                end else begin
                    cyc++;
                    if (cyc > 64) begin
                        check("ready_timeout", cyc, sbq[0].lat);
                        void'(sbq.pop_front());
                        cyc = 0;
                        done_flag = 1;
                    end
                end
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!done_flag && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!done_flag) check("driver_timeout", n, 0);
    endtask

    task automatic issue(input logic [14:0] a);
        @(posedge clk);
        #1;
        bus.address = a;
        done_flag = 0;
        sbq.push_back('{a, model_access(a)});
    endtask

    task automatic access(input logic [14:0] a);
        issue(a);
        wait_done();
    endtask

    task automatic reset_access(input logic [14:0] a);
        @(posedge clk);
        #1;
        clear = 1'b0;
        sbq.delete();
        model_reset();
        bus.address = a;
        #1;
        check("reset_ready", bus.ready, 0);
        check("reset_mem_out", bus.mem_out, 0);
`ifdef CACHE_STATS_EN
        check("reset_access_count", bus.access_count, 0);
        check("reset_hit_count", bus.hit_count, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b1;
        done_flag = 0;
        sbq.push_back('{a, model_access(a)});
        wait_done();
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
        @(posedge clk);
        #1;
        check({tag, "_access_count"}, bus.access_count, exp_acc);
        check({tag, "_hit_count"}, bus.hit_count, exp_hits);
`else
        if (tag.len() == 0) $display("empty stats tag");
`endif
    endtask

    initial begin
        int m0;
        int h0;
        logic [14:0] a;
        int n;
        bus.address = '0;
        bus1.address = '0;

        reset_access(15'd1024);
        for (int i = 1025; i <= 1027; i++) access(15'(i));
        check_stats("basic");

        reset_access(15'd1024);
        access(15'd5120);
        access(15'd1024);
        check_stats("conflict");

        m0 = obs_miss;
        h0 = obs_hit;
        reset_access(15'd1024);
        for (int i = 1025; i <= 9215; i++) access(15'(i));
        check("sweep_misses", obs_miss - m0, 2048);
        check("sweep_hits", obs_hit - h0, 6144);
`ifdef CACHE_STATS_EN
        @(posedge clk);
        #1;
        check("sweep_access_count", bus.access_count, 8192);
        check("sweep_hit_count", bus.hit_count, 6144);
`endif

        issue(15'd2048);
        repeat (2) @(posedge clk);
        reset_access(15'd2048);
        access(15'd1024);
        check_stats("abort");

        a = 15'd0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) != 0) begin
                a = {3'($urandom), 8'd0, 2'($urandom_range(0, 3)),
                     2'($urandom)};
            end
            access(a);
        end
        check_stats("random");

        @(posedge clk);
        #1;
        clear = 1'b0;
        sbq.delete();
        model_reset();
        bus1.address = 15'd1024;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus1.ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("lat1_stall", n, 2);
        check("lat1_data", bus1.mem_out, 1024);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
